// File: rtl/jtdd_obj_romslot.sv
// jtdd_obj_romslot: 2-entry word cache serving object-layer ROM reads, refilled from an SDRAM slot
module jtdd_obj_romslot #(
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [17:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        rom_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [15:0] sdram_dout
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
  state_t           r_st;
  logic [1:0]       r_valid;
  logic [1:0][17:0] r_tag;
  logic [1:0][15:0] r_data;
  logic             r_lru;
  logic [17:0]      r_fetch;
  logic [1:0]       w_hit;
  logic             w_fill, w_dup;
  assign w_hit[0] = r_valid[0] && r_tag[0] == rom_addr;
  assign w_hit[1] = r_valid[1] && r_tag[1] == rom_addr;
  assign rom_ok   = |w_hit;
  assign rom_data = w_hit[1] ? r_data[1] : r_data[0];
  // data_rdy while waiting for the ack counts as ack plus data
  assign w_fill   = data_rdy && r_st != IDLE;
  assign w_dup    = r_valid[!r_lru] && r_tag[!r_lru] == r_fetch;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st       <= IDLE;
      r_valid    <= '0;
      r_tag      <= '0;
      r_data     <= '0;
      r_lru      <= 1'b0;
      r_fetch    <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= OFFSET;
    end else begin
      if (flush) r_valid <= 2'b00;
      if (rom_ok) r_lru <= w_hit[0];
      case (r_st)
        IDLE: if (!rom_ok && !flush) begin
          r_fetch    <= rom_addr;
          sdram_addr <= OFFSET + {4'b0, rom_addr};
          sdram_req  <= 1'b1;
          r_st       <= WAIT_ACK;
        end
        WAIT_ACK: if (sdram_ack || data_rdy) begin
          sdram_req <= 1'b0;
          r_st      <= data_rdy ? IDLE : WAIT_DATA;
        end
        WAIT_DATA: if (data_rdy) r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
      if (w_fill && !w_dup) begin
        r_valid[r_lru] <= 1'b1;
        r_tag[r_lru]   <= r_fetch;
        r_data[r_lru]  <= sdram_dout;
        r_lru          <= !r_lru;
      end
    end
  end
endmodule

// File: tb/tb_jtdd_obj_romslot.sv
// tb_jtdd_obj_romslot: directed vectors and handshake sequences for the OBJ ROM slot cache
module tb_jtdd_obj_romslot;
  localparam logic [21:0] OFFSET = 22'h10000;
  localparam logic [17:0] A = 18'h00010, B = 18'h00011, C = 18'h00020;
  localparam logic [17:0] D = 18'h00030, E = 18'h00031, F = 18'h00040;
  logic        clk = 0, rst = 1, flush = 0, sdram_ack = 0, data_rdy = 0;
  logic [17:0] rom_addr = 18'h00123;
  logic [15:0] sdram_dout = 16'h0, rom_data;
  logic        rom_ok, sdram_req;
  logic [21:0] sdram_addr;
  int checks = 0, failures = 0;
  typedef struct {
    logic [17:0] addr;
    logic        ok;
    logic [15:0] data;
  } vec_t;
  vec_t vecs [20];
  jtdd_obj_romslot #(.OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_ok(rom_ok), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .sdram_dout(sdram_dout)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_req(input string nm);
    int n = 0;
    while (!sdram_req && n < 20) begin
      tick;
      n++;
    end
    chk(nm, {31'b0, sdram_req}, 1);
  endtask
  task automatic serve(input logic [17:0] a, input logic [15:0] d, input int ack_d, input int rdy_d);
    wait_req("req_rise");
    chk("req_addr", {10'b0, sdram_addr}, {10'b0, 22'(OFFSET + {4'b0, a})});
    repeat (ack_d) tick;
    sdram_ack = 1;
    tick;
    sdram_ack = 0;
    repeat (rdy_d) tick;
    data_rdy = 1;
    sdram_dout = d;
    tick;
    data_rdy = 0;
    chk("fill_ok", {31'b0, rom_ok}, 1);
    chk("fill_data", {16'b0, rom_data}, {16'b0, d});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 20; i++)
      vecs[i] = (i % 2) ? '{B, 1'b1, 16'hBBBB} : '{A, 1'b1, 16'hAAAA};
    // reset state and the basic miss with ack at +2 and data at +5
    repeat (2) tick;
    chk("rst_req", {31'b0, sdram_req}, 0);
    chk("rst_addr", {10'b0, sdram_addr}, 32'h10000);
    chk("rst_ok", {31'b0, rom_ok}, 0);
    chk("rst_data", {16'b0, rom_data}, 0);
    rst = 0;
    tick;
    chk("miss_req", {31'b0, sdram_req}, 1);
    chk("miss_addr", {10'b0, sdram_addr}, 32'h10123);
    tick;
    tick;
    sdram_ack = 1;
    chk("miss_ok_pre_ack", {31'b0, rom_ok}, 0);
    tick;
    sdram_ack = 0;
    chk("req_drop_on_ack", {31'b0, sdram_req}, 0);
    tick;
    data_rdy = 1;
    sdram_dout = 16'hBEEF;
    chk("miss_ok_at_rdy", {31'b0, rom_ok}, 0);
    tick;
    data_rdy = 0;
    chk("miss_ok", {31'b0, rom_ok}, 1);
    chk("miss_data", {16'b0, rom_data}, 32'hBEEF);
    // two-address alternation
    rom_addr = A;
    serve(A, 16'hAAAA, 0, 0);
    rom_addr = B;
    serve(B, 16'hBBBB, 1, 2);
    foreach (vecs[i]) begin
      rom_addr = vecs[i].addr;
      #1;
      chk("alt_ok", {31'b0, rom_ok}, {31'b0, vecs[i].ok});
      chk("alt_data", {16'b0, rom_data}, {16'b0, vecs[i].data});
      chk("alt_noreq", {31'b0, sdram_req}, 0);
      tick;
    end
    // LRU: touch A, then C must evict B
    rom_addr = A;
    tick;
    rom_addr = C;
    serve(C, 16'hCCCC, 0, 1);
    rom_addr = A;
    #1;
    chk("lru_a_ok", {31'b0, rom_ok}, 1);
    chk("lru_a_data", {16'b0, rom_data}, 32'hAAAA);
    rom_addr = B;
    #1;
    chk("lru_b_miss", {31'b0, rom_ok}, 0);
    serve(B, 16'hB002, 0, 0);
    // address change during WAIT_DATA
    rom_addr = D;
    wait_req("chg_req_d");
    chk("chg_addr_d", {10'b0, sdram_addr}, {10'b0, 22'(OFFSET + {4'b0, D})});
    sdram_ack = 1;
    tick;
    sdram_ack = 0;
    rom_addr = E;
    tick;
    data_rdy = 1;
    sdram_dout = 16'hDDDD;
    tick;
    data_rdy = 0;
    chk("chg_e_ok_after_d", {31'b0, rom_ok}, 0);
    tick;
    chk("chg_req_e", {31'b0, sdram_req}, 1);
    chk("chg_addr_e", {10'b0, sdram_addr}, {10'b0, 22'(OFFSET + {4'b0, E})});
    sdram_ack = 1;
    tick;
    sdram_ack = 0;
    tick;
    chk("chg_e_ok_wait", {31'b0, rom_ok}, 0);
    data_rdy = 1;
    sdram_dout = 16'hEEEE;
    tick;
    data_rdy = 0;
    chk("chg_e_ok", {31'b0, rom_ok}, 1);
    chk("chg_e_data", {16'b0, rom_data}, 32'hEEEE);
    rom_addr = D;
    #1;
    chk("chg_d_ok", {31'b0, rom_ok}, 1);
    chk("chg_d_data", {16'b0, rom_data}, 32'hDDDD);
    // flush, then ack and data together
    rom_addr = E;
    #1;
    chk("flush_pre_ok", {31'b0, rom_ok}, 1);
    flush = 1;
    tick;
    flush = 0;
    chk("flush_ok", {31'b0, rom_ok}, 0);
    wait_req("early_req");
    sdram_ack = 1;
    data_rdy = 1;
    sdram_dout = 16'hE002;
    tick;
    sdram_ack = 0;
    data_rdy = 0;
    chk("early_req_drop", {31'b0, sdram_req}, 0);
    chk("early_ok", {31'b0, rom_ok}, 1);
    chk("early_data", {16'b0, rom_data}, 32'hE002);
    repeat (3) begin
      tick;
      chk("early_no_second_req", {31'b0, sdram_req}, 0);
    end
    // async reset while waiting for the ack
    rom_addr = F;
    wait_req("arst_req");
    #2;
    rst = 1;
    #1;
    chk("arst_req", {31'b0, sdram_req}, 0);
    chk("arst_addr", {10'b0, sdram_addr}, 32'h10000);
    tick;
    rst = 0;
    data_rdy = 1;
    sdram_dout = 16'h5555;
    tick;
    data_rdy = 0;
    chk("stray_f_ok", {31'b0, rom_ok}, 0);
    chk("stray_new_req", {31'b0, sdram_req}, 1);
    rom_addr = E;
    #1;
    chk("stray_e_ok", {31'b0, rom_ok}, 0);
    tick;
    chk("stray_e_still_miss", {31'b0, rom_ok}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
